seq_div32: RTL
==============

SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 Parameter: WIDTH, default 32, operand, quotient and remainder width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned numerator; sampled with accepted start.
REQ-006 divisor  input  WIDTH  unsigned denominator; sampled with accepted start.
REQ-007 busy  output  1  high while in CALC or DONE.
REQ-008 done  output  1  one-cycle pulse; quotient and remainder valid.
REQ-009 quotient  output  WIDTH  floor(dividend/divisor).
REQ-010 remainder  output  WIDTH  dividend - quotient*divisor.
REQ-011 dz  output  1  divide-by-zero flag; valid with done.

Function
REQ-012 The module SHALL implement an unsigned radix-2 restoring divider, the inverse operation of the team's vedic multipliers: one quotient bit per clock, MSB first.
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 IDLE->CALC SHALL occur on a rising edge with start=1; dividend and divisor are latched internally on that edge.
REQ-015 Inputs SHALL be ignored outside IDLE; start in CALC or DONE has no effect and is not queued.
REQ-016 CALC SHALL run exactly WIDTH iterations, tracked by a log2(WIDTH)+1-bit down-counter.
REQ-017 Each iteration: partial = {rem[WIDTH-1:0], next dividend bit}, WIDTH+1 bits; if partial >= divisor then rem = partial - divisor and q bit = 1, else rem = partial and q bit = 0.
REQ-018 CALC->DONE SHALL follow the final iteration. DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-019 done SHALL be high only in DONE, for exactly one cycle, WIDTH+1 cycles after the start-sampling edge (33 for WIDTH=32).
REQ-020 quotient, remainder and dz SHALL be registered outputs. They update only on entry to DONE and hold until the next entry to DONE.
REQ-021 A new start SHALL be accepted in the first IDLE cycle after DONE; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 Divisor 0 without detection SHALL produce quotient all-ones and remainder = dividend through the normal WIDTH iterations.
REQ-023 No overflow is possible: quotient <= dividend, and remainder < divisor for any nonzero divisor.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE and busy, done, dz, quotient, remainder, the counter and the internal registers SHALL all be 0.
REQ-025 Reset assertion mid-CALC SHALL abort the operation immediately; no done is produced for it.
REQ-026 After rst_n deasserts, the first accepted start SHALL behave identically to the first operation after power-up.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN defined: an accepted start with divisor=0 SHALL go IDLE->DONE directly. done is asserted 1 cycle after the sampling edge, with quotient all-ones, remainder = dividend and dz=1.
REQ-028 Macro DIV_ZERO_DETECT_EN undefined: the dz port SHALL remain present, tied to 0. Divisor 0 follows REQ-022 with the full WIDTH+1 latency.

Verification
REQ-029 dividend=100, divisor=7 -> done exactly 33 cycles after start edge, quotient=14, remainder=2, dz=0.
REQ-030 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=10 -> quotient=0, remainder=5. Both sequences are issued back-to-back, with the second start in the first IDLE cycle after done.
REQ-031 dividend=0x12345678, divisor=0 -> with DIV_ZERO_DETECT_EN: done after 1 cycle, quotient=0xFFFFFFFF, remainder=0x12345678, dz=1. Without the macro: the same values after 33 cycles, dz=0.
REQ-032 Start 1000/3. At cycle 10, pulse start with 9/3 -> ignored; the single done gives quotient=333, remainder=1.
REQ-033 Start 1000/3, then assert rst_n=0 at cycle 15 -> outputs 0 immediately, no done. After release, 1000/3 -> quotient=333, remainder=1 at cycle 33.
REQ-034 Random 10k operand pairs against a reference model, including 0/x, x/x and max/max -> all results match and remainder < divisor.

Source files
------------

// File: rtl/seq_div32.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, MSB first.
// Optional macro DIV_ZERO_DETECT_EN: divisor 0 skips iteration and reports dz.
module seq_div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic             ge;
  logic             last;
  logic             load;
  logic             step;
  logic             zero_div;

`ifdef DIV_ZERO_DETECT_EN
  always_comb zero_div = (divisor == '0);
`else
  always_comb zero_div = 1'b0;
`endif

  // dvd_r shifts dividend bits out of the MSB while quotient bits enter at the LSB
  always_comb begin
    partial  = {rem_r, dvd_r[WIDTH-1]};
    diff     = partial - {1'b0, dsr_r};
    ge       = (partial >= {1'b0, dsr_r});
    rem_step = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    dvd_step = {dvd_r[WIDTH-2:0], ge};
    last     = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_r <= '0;
      dvd_r <= '0;
      dsr_r <= '0;
    end else if (load) begin
      cnt   <= CNT_W'(WIDTH);
      rem_r <= '0;
      dvd_r <= dividend;
      dsr_r <= divisor;
    end else if (step) begin
      cnt   <= cnt - CNT_W'(1);
      rem_r <= rem_step;
      dvd_r <= dvd_step;
    end
  end

  // Result registers capture the final iteration directly so done is not delayed a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (step && last) begin
      quotient  <= dvd_step;
      remainder <= rem_step;
    end else if (load && zero_div) begin
      quotient  <= '1;
      remainder <= dividend;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dz <= 1'b0;
    else if (step && last)     dz <= 1'b0;
    else if (load && zero_div) dz <= 1'b1;
  end
`else
  always_comb dz = 1'b0;
`endif

endmodule
